// File: rtl/button_event_sequencer_pkg.sv
// Shared definitions for the button PIO sequencer: FSM states and PIO register map.
package button_seq_pkg;

    typedef enum logic [3:0] {
        ST_INIT_MASK = 4'd0,
        ST_INIT_CLR  = 4'd1,
        ST_WAIT_POLL = 4'd2,
        ST_RD_EDGE_A = 4'd3,
        ST_RD_EDGE_S = 4'd4,
        ST_CLR_EDGE  = 4'd5,
        ST_HOLDOFF   = 4'd6,
        ST_RD_LVL_A  = 4'd7,
        ST_RD_LVL_S  = 4'd8,
        ST_EMIT      = 4'd9
    } state_e;

    localparam logic [1:0] PIO_DATA = 2'd0;
    localparam logic [1:0] PIO_MASK = 2'd2;
    localparam logic [1:0] PIO_EDGE = 2'd3;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_event_sequencer_cycle_timer.sv
// Loadable down-counter that parks at zero; shared by the poll interval and debounce hold-off.
module cycle_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/button_event_sequencer.sv
// Avalon-MM master that configures and polls the button PIO, debounces presses and
// hands confirmed presses to the note logic over a valid/ready port.
//
// state        | meaning
// INIT_MASK    | write 0 to irq mask (polled operation)
// INIT_CLR     | write 0 to edge capture, start poll interval
// WAIT_POLL    | poll interval countdown; waits for enable at zero
// RD_EDGE_A/S  | read edge capture (address phase / sample phase)
// CLR_EDGE     | clear edge capture, start debounce hold-off
// HOLDOFF      | debounce countdown
// RD_LVL_A/S   | read button level; low confirms the press
// EMIT         | present event until accepted
module button_event_sequencer
    import button_seq_pkg::*;
#(
    parameter int POLL_CYCLES     = 50000,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    output logic [1:0]       m_address,
    output logic             m_chipselect,
    output logic             m_write_n,
    output logic [31:0]      m_writedata,
    input  logic [31:0]      m_readdata,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [CNT_W-1:0] evt_count,
    output logic [CNT_W-1:0] rejects,
    output logic             busy
);

    localparam int TMR_W = $clog2(max2(POLL_CYCLES, DEBOUNCE_CYCLES));
    localparam logic [TMR_W-1:0] POLL_RELOAD = TMR_W'(POLL_CYCLES - 1);
    localparam logic [TMR_W-1:0] DEB_RELOAD  = TMR_W'(DEBOUNCE_CYCLES - 1);

    state_e             state_q, state_d;
    logic [1:0]         addr_q, addr_d;
    logic               cs_q, cs_d;
    logic               wn_q, wn_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   rej_q, rej_d;
    logic               tmr_load;
    logic [TMR_W-1:0]   tmr_val;
    logic               tmr_zero;
    logic               unused_rd;

    assign unused_rd = ^m_readdata[31:1];

    cycle_timer #(.W(TMR_W)) u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    // INIT_MASK leaves only once its write strobe has actually been on the bus,
    // because the bus outputs come out of reset idle.
    always_comb begin
        state_d  = state_q;
        tmr_load = 1'b0;
        tmr_val  = POLL_RELOAD;
        cnt_d    = cnt_q;
        rej_d    = rej_q;
        case (state_q)
            ST_INIT_MASK: if (cs_q) state_d = ST_INIT_CLR;
            ST_INIT_CLR: begin
                state_d  = ST_WAIT_POLL;
                tmr_load = 1'b1;
            end
            ST_WAIT_POLL: if (tmr_zero && enable) state_d = ST_RD_EDGE_A;
            ST_RD_EDGE_A: state_d = ST_RD_EDGE_S;
            ST_RD_EDGE_S: begin
                if (m_readdata[0]) begin
                    state_d = ST_CLR_EDGE;
                end else begin
                    state_d  = ST_WAIT_POLL;
                    tmr_load = 1'b1;
                end
            end
            ST_CLR_EDGE: begin
                state_d  = ST_HOLDOFF;
                tmr_load = 1'b1;
                tmr_val  = DEB_RELOAD;
            end
            ST_HOLDOFF:  if (tmr_zero) state_d = ST_RD_LVL_A;
            ST_RD_LVL_A: state_d = ST_RD_LVL_S;
            ST_RD_LVL_S: begin
                if (!m_readdata[0]) begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = ST_EMIT;
                end else begin
                    rej_d    = rej_q + CNT_W'(1);
                    state_d  = ST_WAIT_POLL;
                    tmr_load = 1'b1;
                end
            end
            ST_EMIT: begin
                if (evt_ready) begin
                    state_d  = ST_WAIT_POLL;
                    tmr_load = 1'b1;
                end
            end
            default: state_d = ST_INIT_MASK;
        endcase
    end

    // Bus and status outputs are registered from the next state so they line up
    // with the state they belong to and never glitch.
    always_comb begin
        addr_d  = PIO_DATA;
        cs_d    = 1'b0;
        wn_d    = 1'b1;
        valid_d = (state_d == ST_EMIT);
        busy_d  = (state_d != ST_WAIT_POLL);
        case (state_d)
            ST_INIT_MASK: begin
                addr_d = PIO_MASK;
                cs_d   = 1'b1;
                wn_d   = 1'b0;
            end
            ST_INIT_CLR, ST_CLR_EDGE: begin
                addr_d = PIO_EDGE;
                cs_d   = 1'b1;
                wn_d   = 1'b0;
            end
            ST_RD_EDGE_A, ST_RD_EDGE_S: addr_d = PIO_EDGE;
            default: addr_d = PIO_DATA;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_INIT_MASK;
            addr_q  <= PIO_DATA;
            cs_q    <= 1'b0;
            wn_q    <= 1'b1;
            valid_q <= 1'b0;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            rej_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cs_q    <= cs_d;
            wn_q    <= wn_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            rej_q   <= rej_d;
        end
    end

    assign m_address    = addr_q;
    assign m_chipselect = cs_q;
    assign m_write_n    = wn_q;
    assign m_writedata  = '0;
    assign evt_valid    = valid_q;
    assign busy         = busy_q;
    assign evt_count    = cnt_q;
    assign rejects      = rej_q;

endmodule

// File: tb/tb_button_event_sequencer.sv
// Self-checking bench for button_event_sequencer with a behavioural button PIO model.
module tb_button_event_sequencer;

    localparam int P  = 8;
    localparam int D  = 4;
    localparam int CW = 4;
    localparam int BUDGET = 300;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          enable = 1'b1;
    logic          evt_ready = 1'b0;
    logic [1:0]    m_address;
    logic          m_chipselect;
    logic          m_write_n;
    logic [31:0]   m_writedata;
    logic [31:0]   m_readdata = '0;
    logic          evt_valid;
    logic          busy;
    logic [CW-1:0] evt_count;
    logic [CW-1:0] rejects;

    int n_vec  = 0;
    int n_miss = 0;
    logic [CW-1:0] exp_cnt = '0;
    logic [CW-1:0] exp_rej = '0;

    logic edge_cap  = 1'b0;
    logic mask_reg  = 1'b1;
    logic btn_level = 1'b1;
    logic inject    = 1'b0;

    always #5 clk = ~clk;

    button_event_sequencer #(
        .POLL_CYCLES     (P),
        .DEBOUNCE_CYCLES (D),
        .CNT_W           (CW)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .m_address    (m_address),
        .m_chipselect (m_chipselect),
        .m_write_n    (m_write_n),
        .m_writedata  (m_writedata),
        .m_readdata   (m_readdata),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_count    (evt_count),
        .rejects      (rejects),
        .busy         (busy)
    );

    // Button PIO: registered readdata, any write to edge capture clears it, a new edge wins.
    always @(posedge clk) begin
        if (inject) edge_cap <= 1'b1;
        else if (m_chipselect && !m_write_n && m_address == 2'd3) edge_cap <= 1'b0;
        if (m_chipselect && !m_write_n && m_address == 2'd2) mask_reg <= m_writedata[0];
        case (m_address)
            2'd0:    m_readdata <= {31'b0, btn_level};
            2'd2:    m_readdata <= {31'b0, mask_reg};
            2'd3:    m_readdata <= {31'b0, edge_cap};
            default: m_readdata <= '0;
        endcase
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string name);
        check(name,
              {m_address, m_chipselect, m_write_n, m_writedata, evt_valid, evt_count, rejects, busy},
              {2'd0, 1'b0, 1'b1, 32'd0, 1'b0, {CW{1'b0}}, {CW{1'b0}}, 1'b1});
    endtask

    task automatic check_init();
        int t = 0;
        while (!m_chipselect && t < 10) begin tick(); t++; end
        check("init_mask_write", {m_chipselect, m_write_n, m_address, m_writedata}, {1'b1, 1'b0, 2'd2, 32'd0});
        tick();
        check("init_clr_write", {m_chipselect, m_write_n, m_address, m_writedata}, {1'b1, 1'b0, 2'd3, 32'd0});
        tick();
        check("init_done_idle", {m_chipselect, m_write_n, busy}, {1'b1 ^ 1'b1, 1'b1, 1'b0});
        check("init_mask_reg", mask_reg, 1'b0);
    endtask

    // One edge with the button held at lvl throughout; accepts any event after rdy_dly cycles.
    task automatic run_attempt(input logic lvl, input int rdy_dly,
                               output logic saw_valid, output logic [CW-1:0] cnt_seen);
        int t = 0;
        int lat = 0;
        saw_valid = 1'b0;
        cnt_seen  = '0;
        btn_level = lvl;
        inject = 1'b1;
        tick();
        inject = 1'b0;
        while (edge_cap && t < BUDGET) begin tick(); t++; end
        while (busy && !evt_valid && t < BUDGET) begin tick(); t++; lat++; end
        check("attempt_in_budget", t < BUDGET, 1'b1);
        if (t >= BUDGET) return;
        check("holdoff_to_result_latency", lat, D + 2);
        saw_valid = evt_valid;
        cnt_seen  = evt_count;
        if (evt_valid) begin
            for (int i = 0; i < rdy_dly; i++) tick();
            check("valid_held_until_ready", {evt_valid, evt_count}, {1'b1, cnt_seen});
            evt_ready = 1'b1;
            tick();
            evt_ready = 1'b0;
            check("valid_drop_after_accept", {evt_valid, busy}, 2'b00);
        end
    endtask

    typedef struct {
        logic          lvl;
        int            rdy;
        logic          exp_valid;
        logic [CW-1:0] exp_cnt;
        logic [CW-1:0] exp_rej;
    } vec_t;

    vec_t tbl[6];

    initial begin
        logic          sv;
        logic [CW-1:0] cs;
        int            acc;
        int            t;
        int            n;
        logic          held_ok;

        tbl[0] = '{1'b0, 0, 1'b1, 4'd1, 4'd0};
        tbl[1] = '{1'b1, 0, 1'b0, 4'd1, 4'd1};
        tbl[2] = '{1'b0, 3, 1'b1, 4'd2, 4'd1};
        tbl[3] = '{1'b0, 0, 1'b1, 4'd3, 4'd1};
        tbl[4] = '{1'b1, 2, 1'b0, 4'd3, 4'd2};
        tbl[5] = '{1'b0, 1, 1'b1, 4'd4, 4'd2};

        repeat (3) tick();
        check_reset_values("reset_values");
        reset_n = 1'b1;
        check_init();

        for (int i = 0; i < 6; i++) begin
            run_attempt(tbl[i].lvl, tbl[i].rdy, sv, cs);
            check($sformatf("tbl%0d_valid", i), sv, tbl[i].exp_valid);
            check($sformatf("tbl%0d_count_seen", i), cs, tbl[i].exp_cnt);
            check($sformatf("tbl%0d_count", i), evt_count, tbl[i].exp_cnt);
            check($sformatf("tbl%0d_rejects", i), rejects, tbl[i].exp_rej);
        end
        exp_cnt = tbl[5].exp_cnt;
        exp_rej = tbl[5].exp_rej;

        // enable low: no bus activity, then a poll read right after enable returns
        enable = 1'b0;
        acc = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (m_chipselect || m_address != 2'd0) acc++;
        end
        check("disabled_no_access", acc, 0);
        check("disabled_not_busy", busy, 1'b0);
        enable = 1'b1;
        tick();
        check("enable_poll_addr", {m_address, m_chipselect}, {2'd3, 1'b0});
        t = 0;
        while (busy && t < 20) begin tick(); t++; end
        check("empty_poll_returns", busy, 1'b0);
        check("empty_poll_counts", {evt_count, rejects}, {exp_cnt, exp_rej});

        // event held pending while a second edge lands in the PIO
        btn_level = 1'b0;
        inject = 1'b1;
        tick();
        inject = 1'b0;
        t = 0;
        while (!evt_valid && t < BUDGET) begin tick(); t++; end
        exp_cnt = exp_cnt + 1'b1;
        check("pend_first_valid", evt_valid, 1'b1);
        check("pend_first_count", evt_count, exp_cnt);
        held_ok = 1'b1;
        acc = 0;
        for (int i = 0; i < 20; i++) begin
            inject = (i == 5);
            tick();
            if (!evt_valid || evt_count != exp_cnt) held_ok = 1'b0;
            if (m_chipselect || m_address != 2'd0) acc++;
        end
        inject = 1'b0;
        check("pend_valid_stable", held_ok, 1'b1);
        check("pend_no_access", acc, 0);
        check("pend_edge_latched", edge_cap, 1'b1);
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        check("pend_accept_drop", evt_valid, 1'b0);
        t = 0;
        while (!evt_valid && t < BUDGET) begin tick(); t++; end
        exp_cnt = exp_cnt + 1'b1;
        check("pend_second_valid", evt_valid, 1'b1);
        check("pend_second_count", evt_count, exp_cnt);
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;

        // randomized presses and bounces against the counting model
        for (int r = 0; r < 40; r++) begin
            logic lvl;
            lvl = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 9)) tick();
            if (!lvl) exp_cnt = exp_cnt + 1'b1;
            else      exp_rej = exp_rej + 1'b1;
            run_attempt(lvl, $urandom_range(0, 4), sv, cs);
            check("rnd_valid", sv, !lvl);
            check("rnd_count", evt_count, exp_cnt);
            check("rnd_rejects", rejects, exp_rej);
        end

        // counter wrap from all-ones
        n = (16 - int'(exp_cnt)) % 16;
        if (n == 0) n = 16;
        for (int k = 0; k < n; k++) begin
            exp_cnt = exp_cnt + 1'b1;
            run_attempt(1'b0, 0, sv, cs);
            if (k == n - 2) check("wrap_pre_count", cs, 4'd15);
        end
        check("wrap_count_zero", cs, 4'd0);
        check("wrap_model_agrees", evt_count, exp_cnt);

        // reset during hold-off aborts and reruns init
        btn_level = 1'b0;
        inject = 1'b1;
        tick();
        inject = 1'b0;
        t = 0;
        while (edge_cap && t < BUDGET) begin tick(); t++; end
        tick();
        check("in_holdoff_before_reset", {busy, evt_valid, m_chipselect}, 3'b100);
        reset_n = 1'b0;
        #1;
        check_reset_values("async_reset_values");
        exp_cnt = '0;
        exp_rej = '0;
        tick();
        reset_n = 1'b1;
        check_init();
        exp_cnt = exp_cnt + 1'b1;
        run_attempt(1'b0, 0, sv, cs);
        check("post_reset_count", cs, 4'd1);
        check("post_reset_rejects", rejects, 4'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/button_event_sequencer.md
# button_event_sequencer

Avalon-MM master that owns and sequences the button PIO slave (data at address 0, irq mask at 2, edge capture at 3, registered readdata, 1-cycle read latency). After reset it configures the PIO. It then polls edge capture, clears it, and waits out a debounce hold-off. It confirms the press by reading the level and emits a counted press event on a valid/ready port to the harp note logic. This lets software and note logic drop raw PIO handling.

## Interface
Parameters:
- POLL_CYCLES, 50000, idle cycles between edge-capture polls (1 ms at 50 MHz); ≥2
- DEBOUNCE_CYCLES, 1000000, hold-off after clearing edge capture (20 ms); ≥1
- CNT_W, 16, width of press counter

Ports:
- clk  in  1  single clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  1 = sequencing allowed; sampled only in WAIT_POLL
- m_address  out  2  PIO address
- m_chipselect  out  1  write qualifier to PIO
- m_write_n  out  1  active-low write strobe
- m_writedata  out  32  PIO write data
- m_readdata  in  32  PIO registered readdata; only bit 0 meaningful
- evt_valid  out  1  press event pending
- evt_ready  in  1  consumer accepts event
- evt_count  out  CNT_W  running count of confirmed presses, stable while evt_valid
- rejects  out  CNT_W  count of edges rejected by level check
- busy  out  1  1 in any state other than WAIT_POLL

## Operation
- States: INIT_MASK → INIT_CLR → WAIT_POLL → RD_EDGE_A → RD_EDGE_S → CLR_EDGE → HOLDOFF → RD_LVL_A → RD_LVL_S → EMIT.
- INIT_MASK: one write cycle with address 2, data 0 (irq disabled; block polls).
- INIT_CLR: one write cycle with address 3, data 0. Then go to WAIT_POLL with the timer loaded to POLL_CYCLES-1.
- WAIT_POLL: count down. At 0 with enable=1, go to RD_EDGE_A. At 0 with enable=0, hold at 0.
- RD_EDGE_A: drive address 3 (chipselect 0, write_n 1) for one cycle.
- RD_EDGE_S: hold address 3 and sample m_readdata[0].
  - 1: go to CLR_EDGE.
  - 0: reload the timer and go to WAIT_POLL.
- CLR_EDGE: one write cycle with address 3, data 0. Load the timer to DEBOUNCE_CYCLES-1 and go to HOLDOFF.
- HOLDOFF: count down to 0, then go to RD_LVL_A.
- RD_LVL_A / RD_LVL_S: read address 0 the same way as the edge read.
  - Bit 0 = 0 (button held low): press confirmed. evt_count += 1, then go to EMIT.
  - Bit 0 = 1: rejects += 1, reload the timer, go to WAIT_POLL.
- EMIT: evt_valid=1 until the cycle with evt_ready=1. Then evt_valid drops next cycle, the timer reloads and the block returns to WAIT_POLL.
- Write cycles: chipselect=1 and write_n=0 for exactly one cycle. In all other states chipselect=0, write_n=1, writedata=0.
- Edges that occur during HOLDOFF or EMIT are latched in the PIO. They are seen at the next poll and then level-checked, so bounce edges are rejected or merged.
- Counters wrap from all-ones to 0 silently.

## Timing
- Reset values: m_address 0, m_chipselect 0, m_write_n 1, m_writedata 0, evt_valid 0, evt_count 0, rejects 0, busy 1. The state is INIT_MASK.
- Reset asserted mid-operation aborts immediately, including mid-write and while EMIT is pending; the event is lost. After release, init reruns.
- Read latency: address driven in cycle N, data sampled at the end of cycle N+1.
- Poll-to-event latency: detection at poll, then 1+1+1+DEBOUNCE_CYCLES+1+1 cycles to evt_valid.
- WAIT_POLL lasts exactly POLL_CYCLES cycles when enable=1.
- evt_valid and evt_ready both 1 in the first EMIT cycle: accept completes in one cycle.
- evt_count updates on the RD_LVL_S→EMIT edge.

## Structure
- Shared package button_seq_pkg:
  - state enum
  - PIO address constants PIO_DATA=0, PIO_MASK=2, PIO_EDGE=3
- One sub-module cycle_timer: loadable down-counter, width $clog2(max(POLL_CYCLES, DEBOUNCE_CYCLES)), with load, load value and zero flag. A single instance is shared by WAIT_POLL and HOLDOFF.

## Test plan
- Reset release with POLL_CYCLES=8, DEBOUNCE_CYCLES=4 → write addr 2 data 0, then write addr 3 data 0, on consecutive cycles; busy drops on the next cycle.
- PIO model edge bit set and level 0 → reads addr 3, writes addr 3 data 0, 4 hold-off cycles, reads addr 0. evt_valid rises with evt_count=1 and rejects=0.
- Edge set but level 1 at confirm (release bounce) → no evt_valid, rejects=1, returns to WAIT_POLL.
- evt_ready held 0 for 20 cycles while a second edge arrives → evt_valid stays 1 with evt_count=1. After ready, the next poll sees the edge and evt_count=2.
- enable=0 → no PIO accesses after init for 100 cycles. Then enable=1 → poll read within 1 cycle.
- evt_count preset via 65535 presses (or force) → next press gives evt_count=0. reset_n pulsed during HOLDOFF → all outputs at reset values and init writes repeat.
